// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
`endif

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        int d;
        d = clk_freq / (baud_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; depth must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign valid = (wptr != rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

    // A push into a full FIFO only lands when the head is leaving on the same edge.
    assign rd_en = pop && valid;
    assign wr_en = push && (!full || rd_en);

    // Empty FIFO presents zero so the data output is defined straight out of reset.
    assign pop_data = valid ? mem[rptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a valid/ready byte FIFO.
// Bit timing is 16x oversampled from a prescaler derived from clk_freq / uart_baud_rate.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_depth     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_rxd,
    output logic [7:0]                        rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              frame_err,
    output logic                              overflow,
    input  logic                              ovf_clr,
    output logic [$clog2(fifo_depth+1)-1:0]   level
);
    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic          sync1;
    logic          rxd_s;
    logic          rxd_d;
    logic [PW-1:0] presc;
    logic          tick;
    logic          start_edge;
    logic          mid_bit;
    rx_state_t     state;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic [7:0]    push_data;
    logic          full;
`ifdef UART_RX_PARITY_EN
    logic          parity_bad;
`endif

    // Synchroniser idles high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxd_s <= sync1;
            rxd_d <= rxd_s;
        end
    end

    assign start_edge = (state == IDLE) && rxd_d && !rxd_s;
    assign tick       = (presc == PW'(DIV - 1));
    assign mid_bit    = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    presc <= '0;
        else if (start_edge || tick) presc <= '0;
        else                         presc <= presc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push      <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == 4'(MID_TICK)) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rxd_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (mid_bit) begin
                        shift   <= {rxd_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= PARITY;
`else
                        if (bit_idx == 3'd7) state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (mid_bit) begin
                        parity_bad <= (rxd_s != ^shift);
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (mid_bit) begin
                        if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                            frame_err <= parity_bad;
                            push      <= !parity_bad;
`else
                            push      <= 1'b1;
`endif
                            push_data <= shift;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO implies rx_valid, so rx_ready alone tells whether the head leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             overflow <= 1'b0;
        else if (push && full && !rx_ready)   overflow <= 1'b1;
        else if (ovf_clr)                     overflow <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .valid     (rx_valid),
        .full      (full),
        .level     (level)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 100 MHz / 1152000 baud (DIV=5, 80 clocks per bit).
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overflow;
    logic       ovf_clr;
    logic [4:0] level;

    int check_count = 0;
    int pass_count  = 0;
    int fe_count    = 0;
    logic early_valid;
    logic late_valid;

    typedef struct {
        logic [7:0] data;
        logic       stop_good;
        logic [4:0] exp_level;
        logic [7:0] exp_head;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .level     (level)
    );

    always #5 clk = ~clk;

    // frame_err is a full-cycle pulse, so each one is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count <= fe_count + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Sends one frame; rx_ready / ovf_clr are pulsed for one cycle at the given frame cycle.
    task automatic apply_stimulus(input logic [7:0] data, input int stop_clks, input logic stop_level,
                                  input int ready_cyc, input int clr_cyc);
        logic [9:0] bits;
        int len;
        int cyc;
        bits = {stop_level, data, 1'b0};
        cyc  = 0;
        for (int b = 0; b < 10; b++) begin
            uart_rxd = bits[b];
            len = (b == 9) ? stop_clks : BIT_CLKS;
            for (int k = 0; k < len; k++) begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 760) early_valid = rx_valid;
                if (cyc == 770) late_valid  = rx_valid;
                rx_ready = (cyc == ready_cyc);
                ovf_clr  = (cyc == clr_cyc);
            end
        end
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pop_one(input string name, input logic [7:0] expected);
        check_output(name, 32'(rx_data), 32'(expected));
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA3, 1'b0, 5'd0, 8'h00, 1};
        vecs[1] = '{8'h3C, 1'b1, 5'd1, 8'h3C, 1};
        vecs[2] = '{8'h81, 1'b1, 5'd2, 8'h3C, 1};
        vecs[3] = '{8'h00, 1'b1, 5'd3, 8'h3C, 1};
        vecs[4] = '{8'hFF, 1'b1, 5'd4, 8'h3C, 1};

        rst      = 1'b0;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_valid", 32'(rx_valid), 32'd0);
        check_output("reset_data", 32'(rx_data), 32'd0);
        check_output("reset_level", 32'(level), 32'd0);
        check_output("reset_overflow", 32'(overflow), 32'd0);
        check_output("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] single byte 0x55");
        apply_stimulus(8'h55, BIT_CLKS, 1'b1, -1, -1);
        check_output("latency_not_yet", 32'(early_valid), 32'd0);
        check_output("latency_valid", 32'(late_valid), 32'd1);
        check_output("single_level1", 32'(level), 32'd1);
        pop_one("single_data", 8'h55);
        check_output("single_level0", 32'(level), 32'd0);
        check_output("single_valid0", 32'(rx_valid), 32'd0);

        $display("[TB] false start");
        uart_rxd = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_output("glitch_valid", 32'(rx_valid), 32'd0);
        check_output("glitch_frame_err", 32'(fe_count), 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].stop_good ? BIT_CLKS : 2 * BIT_CLKS,
                           vecs[i].stop_good, -1, -1);
            check_output($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            check_output($sformatf("vec%0d_fe", i), 32'(fe_count), 32'(vecs[i].exp_fe));
            if (vecs[i].exp_level != 5'd0)
                check_output($sformatf("vec%0d_head", i), 32'(rx_data), 32'(vecs[i].exp_head));
            else
                check_output($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'd0);
        end
        pop_one("drain_3c", 8'h3C);
        pop_one("drain_81", 8'h81);
        pop_one("drain_00", 8'h00);
        pop_one("drain_ff", 8'hFF);
        check_output("table_empty", 32'(level), 32'd0);

        $display("[TB] fill and overflow");
        for (int i = 0; i < 17; i++) apply_stimulus(8'(i), BIT_CLKS, 1'b1, -1, -1);
        check_output("fill_level", 32'(level), 32'd16);
        check_output("fill_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) pop_one($sformatf("fill_drain%0d", i), 8'(i));
        check_output("fill_empty", 32'(level), 32'd0);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check_output("ovf_cleared", 32'(overflow), 32'd0);

        $display("[TB] full push with simultaneous pop");
        for (int i = 0; i < 16; i++) apply_stimulus(8'(i), BIT_CLKS, 1'b1, -1, -1);
        apply_stimulus(8'h10, BIT_CLKS, 1'b1, 763, -1);
        check_output("pushpop_level", 32'(level), 32'd16);
        check_output("pushpop_overflow", 32'(overflow), 32'd0);
        check_output("pushpop_head", 32'(rx_data), 32'h01);

        $display("[TB] overflow set beats clear");
        apply_stimulus(8'h11, BIT_CLKS, 1'b1, -1, 763);
        check_output("setwins_overflow", 32'(overflow), 32'd1);
        check_output("setwins_level", 32'(level), 32'd16);
        for (int i = 1; i < 16; i++) pop_one($sformatf("pp_drain%0d", i), 8'(i));
        check_output("pp_last_head", 32'(rx_data), 32'h10);
        check_output("pp_last_level", 32'(level), 32'd1);

        $display("[TB] reset during frame");
        uart_rxd = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (BIT_CLKS * 4 + 40) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("midrst_valid", 32'(rx_valid), 32'd0);
        check_output("midrst_data", 32'(rx_data), 32'd0);
        check_output("midrst_level", 32'(level), 32'd0);
        check_output("midrst_overflow", 32'(overflow), 32'd0);
        check_output("midrst_frame_err", 32'(frame_err), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        apply_stimulus(8'h12, BIT_CLKS, 1'b1, -1, -1);
        check_output("after_rst_valid", 32'(rx_valid), 32'd1);
        check_output("after_rst_data", 32'(rx_data), 32'h12);
        check_output("after_rst_level", 32'(level), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
